// File: rtl/jk_cnt_pkg.sv
// Shared definitions for the JK-based counter family.
//   MODE_WRAP / MODE_SAT : values for the SATURATE parameter of the counters.
//   clog2()              : bits needed to hold the count range 0..value-1 (minimum 1),
//                          used by instantiating blocks to size WIDTH from MODULUS.
package jk_cnt_pkg;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned top;
    result = 0;
    top    = (value > 0) ? value - 1 : 0;
    for (int i = 0; i < 32; i++) begin
      if ((top >> i) != 0) begin
        result = i + 1;
      end
    end
    return (result == 0) ? 1 : result;
  endfunction

endpackage

// File: rtl/jk_ff.sv
// Single JK flip-flop, rising-edge clocked, asynchronous active-high reset to 0.
//   clk   in  : clock
//   reset in  : async reset, forces q = 0 while high
//   j, k  in  : 00 hold, 01 reset, 10 set, 11 toggle
//   q     out : stored bit
module jk_ff (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      unique case ({j, k})
        2'b00:   q <= q;
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        default: q <= ~q;
      endcase
    end
  end

endmodule

// File: rtl/jk_modn_updown_counter.sv
// Modulo-N up/down counter built from JK flip-flops.
//   clk      in  : rising-edge clock
//   reset    in  : async active-high reset (q = 0, ovf = 0)
//   en       in  : count enable, one step per edge
//   up       in  : 1 = increment, 0 = decrement
//   load     in  : synchronous parallel load, overrides en/up
//   load_val in  : load value, clamped to MODULUS-1 if out of range
//   q        out : current count, always 0..MODULUS-1
//   tc       out : terminal count for the current direction (combinational)
//   ovf      out : one-cycle registered pulse on wrap or saturation attempt
module jk_modn_updown_counter
  import jk_cnt_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 16,
  parameter int unsigned SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  // Elaboration-time legality checks.
  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("jk_modn_updown_counter: WIDTH must be 1..16");
  end
  if (MODULUS < 2 || MODULUS > (32'd1 << WIDTH)) begin : g_bad_modulus
    $error("jk_modn_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end
  if (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) begin : g_bad_mode
    $error("jk_modn_updown_counter: SATURATE must be 0 or 1");
  end

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);
  localparam bit               SatMode = (SATURATE == MODE_SAT);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             ovf_q;
  logic             ovf_d;
  logic             at_max;
  logic             at_zero;

  assign at_max  = (cnt_q == MaxVal);
  assign at_zero = (cnt_q == '0);

  // Next-state value; priority is load, then en, then hold.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    if (load) begin
      cnt_d = (load_val > MaxVal) ? MaxVal : load_val;
    end else if (en) begin
      if (up) begin
        if (at_max) begin
          ovf_d = 1'b1;
          cnt_d = SatMode ? cnt_q : '0;
        end else begin
          cnt_d = cnt_q + One;
        end
      end else begin
        if (at_zero) begin
          ovf_d = 1'b1;
          cnt_d = SatMode ? cnt_q : MaxVal;
        end else begin
          cnt_d = cnt_q - One;
        end
      end
    end
  end

  // Set/reset-only JK drive: toggle is never requested.
  assign j = cnt_d & ~cnt_q;
  assign k = ~cnt_d & cnt_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_ff u_ff (
      .clk   (clk),
      .reset (reset),
      .j     (j[i]),
      .k     (k[i]),
      .q     (cnt_q[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign q   = cnt_q;
  assign ovf = ovf_q;
  assign tc  = up ? at_max : at_zero;

endmodule

// File: tb/tb_jk_modn_updown_counter.sv
// Directed bench for jk_modn_updown_counter: wrap (4b/mod 10), saturate (4b/mod 10)
// and full-range wrap (8b/mod 256) instances, table vectors plus hand sequences.
module tb_jk_modn_updown_counter;

  logic clk = 1'b0;
  logic reset;

  logic       w_en, w_up, w_load;
  logic [3:0] w_lv, w_q;
  logic       w_tc, w_ovf;

  logic       s_en, s_up, s_load;
  logic [3:0] s_lv, s_q;
  logic       s_tc, s_ovf;

  logic       b_en, b_up, b_load;
  logic [7:0] b_lv, b_q;
  logic       b_tc, b_ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       load;
    logic       en;
    logic       up;
    logic [3:0] lv;
    logic [3:0] exp_q;
    logic       exp_ovf;
    logic       exp_tc;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  jk_modn_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .en(w_en), .up(w_up), .load(w_load), .load_val(w_lv),
    .q(w_q), .tc(w_tc), .ovf(w_ovf)
  );

  jk_modn_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .en(s_en), .up(s_up), .load(s_load), .load_val(s_lv),
    .q(s_q), .tc(s_tc), .ovf(s_ovf)
  );

  jk_modn_updown_counter #(.WIDTH(8), .MODULUS(256), .SATURATE(0)) u_big (
    .clk(clk), .reset(reset), .en(b_en), .up(b_up), .load(b_load), .load_val(b_lv),
    .q(b_q), .tc(b_tc), .ovf(b_ovf)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic ld, input logic e, input logic u, input logic [3:0] lv,
                         input logic [3:0] eq, input logic eo, input logic et);
    vec_t v;
    v.load = ld; v.en = e; v.up = u; v.lv = lv;
    v.exp_q = eq; v.exp_ovf = eo; v.exp_tc = et;
    vecs.push_back(v);
  endtask

  // Inputs change 1 time unit after a rising edge; outputs sampled 1 unit after the next.
  task automatic step_w(input logic ld, input logic e, input logic u, input logic [3:0] lv);
    w_load = ld; w_en = e; w_up = u; w_lv = lv;
    @(posedge clk); #1;
  endtask

  task automatic step_s(input logic ld, input logic e, input logic u, input logic [3:0] lv);
    s_load = ld; s_en = e; s_up = u; s_lv = lv;
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic ld, input logic e, input logic u, input logic [7:0] lv);
    b_load = ld; b_en = e; b_up = u; b_lv = lv;
    @(posedge clk); #1;
  endtask

  initial begin
    // Up count from reset: 1..9, 0, 1, 2; ovf only on 9->0; tc while q = 9.
    for (int i = 1; i <= 12; i++) begin
      add_vec(1'b0, 1'b1, 1'b1, 4'd0, 4'(i % 10), (i == 10), (i == 9));
    end
    // Down from 0: wrap to 9 with ovf, then 8, 7.
    add_vec(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    add_vec(1'b0, 1'b1, 1'b0, 4'd0, 4'd9, 1'b1, 1'b0);
    add_vec(1'b0, 1'b1, 1'b0, 4'd0, 4'd8, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 1'b0, 4'd0, 4'd7, 1'b0, 1'b0);
    // Loads: in range, clamped, load beats en.
    add_vec(1'b1, 1'b0, 1'b1, 4'd5,  4'd5, 1'b0, 1'b0);
    add_vec(1'b1, 1'b0, 1'b1, 4'd13, 4'd9, 1'b0, 1'b1);
    add_vec(1'b1, 1'b1, 1'b1, 4'd3,  4'd3, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 1'b1, 4'd0,  4'd3, 1'b0, 1'b0);

    reset = 1'b1;
    w_en = 0; w_up = 1; w_load = 0; w_lv = '0;
    s_en = 0; s_up = 1; s_load = 0; s_lv = '0;
    b_en = 0; b_up = 1; b_load = 0; b_lv = '0;
    #12;
    check("reset_w_q", w_q, 0);
    check("reset_w_ovf", w_ovf, 0);
    check("reset_w_tc", w_tc, 0);
    check("reset_s_q", s_q, 0);
    check("reset_b_q", b_q, 0);
    check("reset_b_ovf", b_ovf, 0);
    #1 reset = 1'b0;

    foreach (vecs[i]) begin
      step_w(vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].lv);
      check($sformatf("w_vec%0d_q", i), w_q, vecs[i].exp_q);
      check($sformatf("w_vec%0d_ovf", i), w_ovf, vecs[i].exp_ovf);
      check($sformatf("w_vec%0d_tc", i), w_tc, vecs[i].exp_tc);
    end

    // Saturate: hold at 9 going up, ovf on every attempt; hold at 0 going down.
    step_s(1'b1, 1'b0, 1'b1, 4'd9);
    check("sat_load_q", s_q, 9);
    check("sat_load_tc", s_tc, 1);
    for (int i = 0; i < 3; i++) begin
      step_s(1'b0, 1'b1, 1'b1, 4'd0);
      check($sformatf("sat_up%0d_q", i), s_q, 9);
      check($sformatf("sat_up%0d_ovf", i), s_ovf, 1);
    end
    step_s(1'b1, 1'b0, 1'b0, 4'd0);
    check("sat_load0_ovf", s_ovf, 0);
    step_s(1'b0, 1'b1, 1'b0, 4'd0);
    check("sat_dn_q", s_q, 0);
    check("sat_dn_ovf", s_ovf, 1);
    check("sat_dn_tc", s_tc, 1);
    step_s(1'b0, 1'b0, 1'b0, 4'd0);
    check("sat_idle_ovf", s_ovf, 0);

    // Full 8-bit range: 254 -> 255, 0, 1 then hold.
    step_b(1'b1, 1'b0, 1'b1, 8'd254);
    check("big_load_q", b_q, 254);
    step_b(1'b0, 1'b1, 1'b1, 8'd0);
    check("big_255_q", b_q, 255);
    check("big_255_ovf", b_ovf, 0);
    check("big_255_tc", b_tc, 1);
    step_b(1'b0, 1'b1, 1'b1, 8'd0);
    check("big_0_q", b_q, 0);
    check("big_0_ovf", b_ovf, 1);
    step_b(1'b0, 1'b1, 1'b1, 8'd0);
    check("big_1_q", b_q, 1);
    check("big_1_ovf", b_ovf, 0);
    for (int i = 0; i < 5; i++) begin
      step_b(1'b0, 1'b0, 1'b1, 8'd0);
      check($sformatf("big_hold%0d_q", i), b_q, 1);
      check($sformatf("big_hold%0d_ovf", i), b_ovf, 0);
    end

    // Async reset clears a live ovf pulse without an edge.
    step_w(1'b1, 1'b0, 1'b1, 4'd9);
    step_w(1'b0, 1'b1, 1'b1, 4'd0);
    check("pre_rst_ovf", w_ovf, 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_ovf", w_ovf, 0);
    check("async_rst_q0", w_q, 0);
    #1 reset = 1'b0;

    // Reset mid-count at q = 6.
    step_w(1'b1, 1'b0, 1'b1, 4'd0);
    for (int i = 0; i < 6; i++) begin
      step_w(1'b0, 1'b1, 1'b1, 4'd0);
    end
    check("mid_pre_q", w_q, 6);
    #2 reset = 1'b1;
    #1;
    check("mid_async_q", w_q, 0);
    check("mid_async_ovf", w_ovf, 0);
    @(posedge clk); #1;
    check("mid_held_q", w_q, 0);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check("mid_resume_q", w_q, 1);
    @(posedge clk); #1;
    check("mid_resume2_q", w_q, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
